// File: rtl/pdm_capture.sv
// PDM microphone capture: generates the mic clock, counts ones over fixed windows
// and streams one saturated amplitude sample per window into a sample RAM.
module pdm_capture #(
  parameter int  CLK_FREQ     = 100,
  parameter int  MIC_FREQ     = 2500000,
  parameter int  RAM_SIZE     = 16384,
  parameter int  SAMPLE_COUNT = 128,
  localparam int ADDR_W       = $clog2(RAM_SIZE),
  localparam int SAMPLE_BITS  = $clog2(SAMPLE_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_capture,
  output logic                   m_clk,
  input  logic                   m_data,
  output logic [ADDR_W-1:0]      ram_wraddr,
  output logic [SAMPLE_BITS-1:0] ram_wrdata,
  output logic                   ram_we,
  output logic                   capture_active,
  output logic                   capture_done,
  output logic [15:0]            led
);

  localparam int HALF  = (CLK_FREQ * 1000000) / (2 * MIC_FREQ);
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [CNT_W-1:0]       HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [SAMPLE_BITS-1:0] BIT_LAST  = SAMPLE_BITS'(SAMPLE_COUNT - 1);
  localparam logic [SAMPLE_BITS:0]   SAT_MAX   = (SAMPLE_BITS + 1)'(SAMPLE_COUNT - 1);
  localparam logic [ADDR_W-1:0]      ADDR_LAST = ADDR_W'(RAM_SIZE - 1);

  logic [CNT_W-1:0]       half_cnt_q, half_cnt_d;
  logic                   m_clk_q, m_clk_d;
  logic [1:0]             data_sync_q, data_sync_d;
  logic [2:0]             start_sync_q, start_sync_d;
  logic                   active_q, active_d;
  logic                   done_q, done_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [SAMPLE_BITS-1:0] wrdata_q, wrdata_d;
  logic [SAMPLE_BITS-1:0] bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_BITS:0]   ones_q, ones_d;
  logic [15:0]            led_q, led_d;

  logic                   half_wrap;
  logic                   bit_event;
  logic                   start;
  logic [SAMPLE_BITS:0]   ones_sum;
  logic [SAMPLE_BITS-1:0] sample_val;
  logic [3:0]             addr_top;
  logic [15:0]            therm;

  always_comb begin
    half_wrap  = (half_cnt_q == HALF_LAST);
    // A bit event is the cycle on which m_clk is driven from 1 to 0
    bit_event  = half_wrap && m_clk_q;
    start      = start_sync_q[1] && !start_sync_q[2];
    ones_sum   = ones_q + (SAMPLE_BITS + 1)'(data_sync_q[1]);
    sample_val = (ones_sum > SAT_MAX) ? SAT_MAX[SAMPLE_BITS-1:0] : ones_sum[SAMPLE_BITS-1:0];
    addr_top   = addr_q[ADDR_W-1 -: 4];
    therm      = '0;
    for (int i = 0; i < 16; i++) begin
      therm[i] = (addr_top >= 4'(i));
    end
  end

  always_comb begin
    half_cnt_d   = half_wrap ? '0 : half_cnt_q + 1'b1;
    m_clk_d      = m_clk_q ^ half_wrap;
    data_sync_d  = {data_sync_q[0], m_data};
    start_sync_d = {start_sync_q[1:0], start_capture};
    active_d     = active_q;
    done_d       = 1'b0;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wrdata_d     = wrdata_q;
    bit_cnt_d    = bit_cnt_q;
    ones_d       = ones_q;
    led_d        = led_q;

    if (start) begin
      // Restart wins over any in-flight window; a pending write still completes
      active_d  = 1'b1;
      addr_d    = '0;
      bit_cnt_d = '0;
      ones_d    = '0;
      led_d     = '0;
    end else begin
      if (we_q) begin
        if (addr_q == ADDR_LAST) begin
          addr_d   = '0;
          active_d = 1'b0;
          done_d   = 1'b1;
          led_d    = '1;
        end else begin
          addr_d = addr_q + 1'b1;
          led_d  = therm;
        end
      end else if (active_q) begin
        led_d = therm;
      end

      if (active_q && bit_event) begin
        if (bit_cnt_q == BIT_LAST) begin
          wrdata_d  = sample_val;
          we_d      = 1'b1;
          bit_cnt_d = '0;
          ones_d    = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          ones_d    = ones_sum;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt_q   <= '0;
      m_clk_q      <= 1'b0;
      data_sync_q  <= '0;
      start_sync_q <= '0;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wrdata_q     <= '0;
      bit_cnt_q    <= '0;
      ones_q       <= '0;
      led_q        <= '0;
    end else begin
      half_cnt_q   <= half_cnt_d;
      m_clk_q      <= m_clk_d;
      data_sync_q  <= data_sync_d;
      start_sync_q <= start_sync_d;
      active_q     <= active_d;
      done_q       <= done_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wrdata_q     <= wrdata_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_q       <= ones_d;
      led_q        <= led_d;
    end
  end

  assign m_clk          = m_clk_q;
  assign ram_wraddr     = addr_q;
  assign ram_wrdata     = wrdata_q;
  assign ram_we         = we_q;
  assign capture_active = active_q;
  assign capture_done   = done_q;
  assign led            = led_q;

endmodule

// File: doc/pdm_capture.md
PDM_CAPTURE -- requirements
Module: pdm_capture

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100, system clock in MHz.
REQ-002 SHALL have parameter MIC_FREQ, default 2500000, PDM mic clock in Hz; HALF = CLK_FREQ*1e6/(2*MIC_FREQ), 20 at defaults.
REQ-003 SHALL have parameter RAM_SIZE, default 16384, sample RAM depth (power of 2, >=16).
REQ-004 SHALL have parameter SAMPLE_COUNT, default 128, PDM bits per sample; SAMPLE_BITS = clog2(SAMPLE_COUNT).
REQ-005 clk  in  1  system clock; all logic on rising edge; single clock domain.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 start_capture  in  1  asynchronous pushbutton; rising edge starts capture.
REQ-008 m_clk  out  1  clock to PDM microphone.
REQ-009 m_data  in  1  PDM bit stream from microphone, asynchronous.
REQ-010 ram_wraddr  out  clog2(RAM_SIZE)  sample RAM write address.
REQ-011 ram_wrdata  out  SAMPLE_BITS  amplitude sample to RAM.
REQ-012 ram_we  out  1  one-cycle RAM write strobe.
REQ-013 capture_active  out  1  high while capture in progress.
REQ-014 capture_done  out  1  one-cycle pulse after last RAM write.
REQ-015 led  out  16  capture progress bar.

Function
REQ-016 m_clk SHALL toggle every HALF clk cycles, free-running whether or not capture is active.
REQ-017 m_data SHALL pass a 2-flop synchronizer; a "bit event" SHALL occur on the clk cycle m_clk is driven 1->0, sampling the synchronized bit.
REQ-018 start_capture SHALL pass a 3-flop synchronizer; start = bits[2:1]==01, a single cycle per press.
REQ-019 On start: capture_active<=1, ram_wraddr<=0, bit counter<=0, ones accumulator<=0, led<=0; the first window begins at the next bit event.
REQ-020 Each bit event while active SHALL increment the bit counter mod SAMPLE_COUNT and add the sampled bit to an accumulator SAMPLE_BITS+1 wide.
REQ-021 On the bit event completing SAMPLE_COUNT bits, ram_wrdata SHALL be min(ones including that bit, SAMPLE_COUNT-1) and ram_we SHALL pulse high the next clk cycle; the accumulator SHALL clear for the next window.
REQ-022 ram_wraddr SHALL hold stable during ram_we and increment by 1 on the cycle after ram_we.
REQ-023 After the write to address RAM_SIZE-1: ram_wraddr wraps to 0, capture_active<=0, capture_done pulses for 1 cycle, aligned with the address wrap.
REQ-024 A start while capture_active SHALL restart per REQ-019; a partial window is discarded with no write.
REQ-025 A start coincident with a ram_we cycle SHALL let that write complete; restart takes effect the same cycle, so the next write goes to address 0.
REQ-026 led[i] SHALL be 1 when capture_active and ram_wraddr[MSB:MSB-3] >= i; on done all 16 LEDs SHALL be 1 and hold until the next start.
REQ-027 While inactive, ram_we SHALL stay 0 and the accumulator and bit counter SHALL hold.
REQ-028 Sample period at defaults SHALL be 2*HALF*SAMPLE_COUNT = 5120 clk cycles.

Reset
REQ-029 rst_n low SHALL immediately force m_clk=0, ram_we=0, ram_wraddr=0, ram_wrdata=0, capture_active=0, capture_done=0, led=0, and clear all counters and synchronizers.
REQ-030 Reset mid-capture SHALL abort with no further writes; after release the block idles until a new start edge.
REQ-031 The first m_clk rising edge after release SHALL occur HALF cycles after rst_n is sampled high.

Verification
REQ-032 m_data=1 constant, start -> every ram_wrdata=127 (saturated), ram_we spaced 5120 cycles, addresses 0,1,2...
REQ-033 m_data=0 constant -> all writes 0; m_data alternating per bit event -> all writes 64.
REQ-034 RAM_SIZE=16, m_data random -> exactly 16 writes, addresses 0..15, capture_done one cycle after write 15, capture_active falls, led=16'hFFFF.
REQ-035 Second start after 3 writes -> no write for the partial window; next write at address 0.
REQ-036 rst_n asserted mid-window -> all outputs zero immediately; no ram_we until a new start; m_clk restarts per REQ-031.
REQ-037 Start pulse shorter than 3 clk cycles and glitches on m_data -> exactly one capture start; no X on any output.
